// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: funct3 encodings
// and the controller state type.
package div_pkg;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // The bit shifted out of rem stays in the compare so divisors >= 2^(XLEN-1) divide correctly.
  always_comb begin
    shifted  = {1'b0, rem, dvd_msb};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[XLEN+1];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |A| < |B|.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      func,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] S
);

  localparam int unsigned CW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, dvd_q, dvd_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, s_q, s_d;
  logic [1:0]      func_q, func_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, step_rem;
  logic            step_q;
  logic            func_unused;

  assign func_unused = func[2];

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[XLEN-1]),
    .divisor  (b_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    s_d     = s_q;
    func_d  = func_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;

    sgn   = ~func_q[0];
    a_neg = sgn & a_q[XLEN-1];
    b_neg = sgn & b_q[XLEN-1];
    a_abs = a_neg ? -a_q : a_q;
    b_abs = b_neg ? -b_q : b_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = A;
            b_d     = B;
            func_d  = func[1:0];
            state_d = PREP;
          end
        end
        PREP: begin
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dvd_d   = a_abs;
          b_d     = b_abs;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
          // Special results are preloaded unsigned and routed through FIX for S selection.
          if (b_q == '0) begin
            quo_d   = '1;
            rem_d   = a_q;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end else if (sgn && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
            quo_d   = a_q;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_abs < b_abs) begin
            quo_d   = '0;
            rem_d   = a_q;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end
`endif
        end
        ITER: begin
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = FIX;
        end
        FIX: begin
          s_d     = func_q[1] ? (rneg_q ? -rem_q : rem_q)
                              : (qneg_q ? -quo_q : quo_q);
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      s_q     <= '0;
      func_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      s_q     <= s_d;
      func_q  <= func_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] A = '0;
  logic [XLEN-1:0] B = '0;
  logic [2:0]      func = FUNC_DIVU;
  logic            busy, done;
  logic [XLEN-1:0] S;

  int n_assert = 0;
  int n_fail   = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .A     (A),
    .B     (B),
    .func  (func),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] f);
    logic [63:0] q, r;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (!f[0] && a == MIN_NEG && b == '1) begin
      q = a;
      r = '0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] f);
    logic [63:0] ma, mb;
    ma = (!f[0] && a[63]) ? -a : a;
    mb = (!f[0] && b[63]) ? -b : b;
    if (b == 64'd0) return 2;
    if (!f[0] && a == MIN_NEG && b == '1) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return XLEN + 2;
`endif
    return XLEN + 2;
  endfunction

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f);
    logic [63:0] exp_s;
    int exp_lat, n;
    bit seen;
    exp_s   = ref_result(a, b, f);
    exp_lat = ref_latency(a, b, f);
    seen    = 1'b0;
    n       = 0;
    @(negedge clk);
    A = a; B = b; func = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = {$urandom(), $urandom()};
    B = {$urandom(), $urandom()};
    chk({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else if (!busy) begin
        chk({tag, " busy_dropped_early"}, {63'd0, busy}, 64'd1);
        n = 200;
      end
      // A start while busy must be ignored.
      if (n == 3) begin start = 1'b1; func = FUNC_DIVU; end
      if (n == 4) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, seen ? 64'(n) : '1, 64'(exp_lat));
    chk({tag, " S"}, S, exp_s);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
    chk({tag, " busy_idle"}, {63'd0, busy}, 64'd0);
    chk({tag, " S_held"}, S, exp_s);
  endtask

  initial begin
    logic [63:0] a, b, s_before;
    logic [2:0]  f;
    int          mode, done_cnt;

    #2 reset = 1'b1;
    #1;
    chk("reset S", S, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("divu_100_7", 64'd100, 64'd7, FUNC_DIVU);
    run_op("rem_m100_7", -64'sd100, 64'd7, FUNC_REM);
    run_op("div_m100_7", -64'sd100, 64'd7, FUNC_DIV);
    run_op("div_b0", 64'd5, 64'd0, FUNC_DIV);
    run_op("remu_b0", 64'd5, 64'd0, FUNC_REMU);
    run_op("div_ovf", MIN_NEG, '1, FUNC_DIV);
    run_op("rem_ovf", MIN_NEG, '1, FUNC_REM);
    run_op("divu_ovf_ops", MIN_NEG, '1, FUNC_DIVU);
    run_op("rem_m3_10", -64'sd3, 64'd10, FUNC_REM);
    run_op("divu_big_b", '1, 64'hFFFF_FFFF_FFFF_FFFE, FUNC_DIVU);
    run_op("remu_big_b", 64'hFFFF_FFFF_FFFF_FFFE, '1, FUNC_REMU);
    run_op("div_minneg_3", MIN_NEG, 64'd3, FUNC_DIV);

    for (int i = 0; i < 20; i++) begin
      mode = $urandom_range(0, 4);
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      case (mode)
        1: b = b >> $urandom_range(40, 63);
        2: a = a >> $urandom_range(1, 63);
        3: begin a = -(a >> 40); b = b >> 50; end
        4: if ($urandom_range(0, 1) == 0) b = 64'd0;
        default: ;
      endcase
      f = 3'(4 + $urandom_range(0, 3));
      run_op("random", a, b, f);
    end

    // Flush mid-iteration: no done, S untouched.
    s_before = S;
    @(negedge clk);
    A = 64'd1000; B = 64'd3; func = FUNC_DIVU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush S", S, s_before);
    done_cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("flush no_done", 64'(done_cnt), 64'd0);

    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_over_start busy", {63'd0, busy}, 64'd0);

    run_op("after_flush", 64'd1000, 64'd3, FUNC_DIVU);

    // Asynchronous reset mid-iteration.
    @(negedge clk);
    A = 64'd12345; B = 64'd11; func = FUNC_REMU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset S", S, 64'd0);
    chk("async_reset busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("after_reset", 64'd12345, 64'd11, FUNC_REMU);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
